sel_switch_ctrl: RTL and testbench
==================================

Name: sel_switch_ctrl

Overview:
- Upstream control stage for the 2:1 select mux. That mux outputs b only when sel_b1 & sel_b2, and a otherwise.
- Converts an asynchronous "select b" request into a glitch-free, qualified, two-phase sel_b1/sel_b2 pair.
- Switch-to-b order: arm (sel_b1) then commit (sel_b2). Switch-to-a order is the reverse.
- Also provides a synchronous force-to-a override and a switch counter.

Parameters:
- HOLD_CYCLES, 4: consecutive synchronized cycles the request must be stable before a switch; legal range 1..255.
- CNT_W, 8: width of switch_cnt.

Ports:
- clk  in  1  rising-edge clock.
- areset_n  in  1  asynchronous active-low reset.
- req_b  in  1  asynchronous request: 1 = select b, 0 = select a.
- force_a  in  1  synchronous (clk domain) override; forces path a; priority over req_b.
- sel_b1  out  1  arm select to mux, registered.
- sel_b2  out  1  commit select to mux, registered.
- busy  out  1  registered; 1 while in QUAL_B, ARM_B, QUAL_A or DISARM.
- switch_cnt  out  CNT_W  number of entries into SEL_B, saturating.

Behaviour:
- Reset: areset_n low asynchronously clears everything. State = IDLE_A; sel_b1 = sel_b2 = busy = 0; switch_cnt = 0; qual counter = 0; sync flops = 0.
- Reset release is synchronous to clk.
- Synchronizer: req_b passes a 2-flop synchronizer, giving req_s. force_a is used unsynchronized.
- All outputs are flops loaded from next-state decode. No combinational output paths.
- State outputs (sel_b1, sel_b2):
  - IDLE_A: 0, 0.
  - QUAL_B: 0, 0.
  - ARM_B: 1, 0.
  - SEL_B: 1, 1.
  - QUAL_A: 1, 1.
  - DISARM: 1, 0.
- Transitions (evaluated each rising edge, force_a checked first):
  - IDLE_A: if force_a=0 and req_s=1, go to QUAL_B with cnt=0.
  - QUAL_B:
    - force_a=1 or req_s=0 → IDLE_A, cnt=0.
    - Else if cnt==HOLD_CYCLES-1 → ARM_B.
    - Else cnt++.
  - ARM_B: force_a=1 → DISARM. Else → SEL_B, and switch_cnt++ (saturates at all-ones).
  - SEL_B: force_a=1 → DISARM. Else if req_s=0 → QUAL_A with cnt=0.
  - QUAL_A:
    - force_a=1 → DISARM.
    - req_s=1 → SEL_B, cnt=0; switch_cnt not incremented.
    - Else if cnt==HOLD_CYCLES-1 → DISARM.
    - Else cnt++.
  - DISARM: always → IDLE_A.
- Latency to b: req_b first sampled at edge k gives sel_b1=1 after edge k+HOLD_CYCLES+2 and sel_b2=1 after edge k+HOLD_CYCLES+3. HOLD=4: arm at k+6, commit at k+7.
- Latency to a: symmetric. sel_b2 falls after edge k+HOLD_CYCLES+2; sel_b1 falls one edge later.
- Latency for force_a: sel_b2 falls on the first edge with force_a=1 (from ARM_B, SEL_B or QUAL_A); sel_b1 falls on the next edge.
- Invariant: sel_b2=1 implies sel_b1=1, in every cycle including reset and force.
- Both selects never change on the same edge, except asynchronous reset clearing both.
- Request glitches shorter than HOLD_CYCLES synchronized cycles never change sel_b2.
- Reset mid-switch (any state): immediate return to the reset values; no partial sequence resumes.
- Qual counter width = $clog2(HOLD_CYCLES+1). HOLD_CYCLES=1 skips counting: one cycle in QUAL_B/QUAL_A.

Decomposition:
- Package sel_ctrl_pkg:
  - typedef enum logic [2:0] sel_state_t {IDLE_A, QUAL_B, ARM_B, SEL_B, QUAL_A, DISARM}.
  - localparam for default HOLD_CYCLES.
- Sub-module sync_2ff: 1-bit, same clk/areset_n, reset value 0. Reusable by other blocks.
- FSM, counters and output flops stay in sel_switch_ctrl.

Test Plan:
- Reset check: areset_n low mid-cycle while in SEL_B → sel_b1, sel_b2, busy and switch_cnt are 0 immediately, before the next clk edge. Hold req_b=0 after release → outputs stay 0.
- Clean switch, HOLD=4: req_b 0→1 at edge 10 → sel_b1=1 after edge 16, sel_b2=1 after edge 17, switch_cnt=1, busy=1 on edges 12–16 only.
- Glitch rejection: req_b high for 3 cycles, then low → sel_b1=sel_b2=0 throughout; state returns to IDLE_A; switch_cnt unchanged.
- Switch back with bounce: in SEL_B, req_b low for 2 cycles, then high → sel_b2 stays 1 and switch_cnt is unchanged. Then a sustained low → sel_b2 falls after edge k+6, sel_b1 after edge k+7.
- force_a: in SEL_B with req_b=1, pulse force_a for 1 cycle → sel_b2 falls on that edge, sel_b1 on the next. Re-arming then takes the full HOLD_CYCLES+3. Assert the sel_b2→sel_b1 invariant every cycle.
- Counter saturation, CNT_W=2: 5 full switch cycles → switch_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/sel_ctrl_pkg.sv
// Shared types and defaults for the select-switch control slice.
package sel_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE_A,
    QUAL_B,
    ARM_B,
    SEL_B,
    QUAL_A,
    DISARM
  } sel_state_t;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT       = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic areset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a cycle to resolve.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sel_switch_ctrl.sv
// Qualified two-phase select control for the downstream 2:1 mux:
// arm (sel_b1) then commit (sel_b2) towards b, reverse order towards a.
module sel_switch_ctrl
  import sel_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             req_b,
  input  logic             force_a,
  output logic             sel_b1,
  output logic             sel_b2,
  output logic             busy,
  output logic [CNT_W-1:0] switch_cnt
);

  localparam int unsigned    QW    = $clog2(HOLD_CYCLES + 1);
  localparam logic [QW-1:0]  QLAST = QW'(HOLD_CYCLES - 1);

  sel_state_t       state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [CNT_W-1:0] swcnt_q, swcnt_d;
  logic             sel_b1_q, sel_b1_d;
  logic             sel_b2_q, sel_b2_d;
  logic             busy_q, busy_d;
  logic             req_s;

  sync_2ff u_req_sync (
    .clk      (clk),
    .areset_n (areset_n),
    .d_i      (req_b),
    .q_o      (req_s)
  );

  // State, qualification counter and switch counter registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE_A;
      qcnt_q  <= '0;
      swcnt_q <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      swcnt_q <= swcnt_d;
    end
  end

  // Next-state decode; force_a has priority over the request in every state.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    swcnt_d = swcnt_q;
    case (state_q)
      IDLE_A: begin
        if (!force_a && req_s) begin
          state_d = QUAL_B;
          qcnt_d  = '0;
        end
      end
      QUAL_B: begin
        if (force_a || !req_s) begin
          state_d = IDLE_A;
          qcnt_d  = '0;
        end else if (qcnt_q == QLAST) begin
          state_d = ARM_B;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      ARM_B: begin
        if (force_a) begin
          state_d = DISARM;
        end else begin
          state_d = SEL_B;
          if (swcnt_q != '1) swcnt_d = swcnt_q + CNT_W'(1);
        end
      end
      SEL_B: begin
        if (force_a) begin
          state_d = DISARM;
        end else if (!req_s) begin
          state_d = QUAL_A;
          qcnt_d  = '0;
        end
      end
      QUAL_A: begin
        if (force_a) begin
          state_d = DISARM;
        end else if (req_s) begin
          state_d = SEL_B;
          qcnt_d  = '0;
        end else if (qcnt_q == QLAST) begin
          state_d = DISARM;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      DISARM:  state_d = IDLE_A;
      default: state_d = IDLE_A;
    endcase
  end

  // Output decode from the next state, so the output flops track the state register.
  always_comb begin
    sel_b1_d = 1'b0;
    sel_b2_d = 1'b0;
    busy_d   = 1'b0;
    case (state_d)
      IDLE_A: ;
      QUAL_B: busy_d = 1'b1;
      ARM_B: begin
        sel_b1_d = 1'b1;
        busy_d   = 1'b1;
      end
      SEL_B: begin
        sel_b1_d = 1'b1;
        sel_b2_d = 1'b1;
      end
      QUAL_A: begin
        sel_b1_d = 1'b1;
        sel_b2_d = 1'b1;
        busy_d   = 1'b1;
      end
      DISARM: begin
        sel_b1_d = 1'b1;
        busy_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs: no combinational path reaches the mux selects.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sel_b1_q <= 1'b0;
      sel_b2_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sel_b1_q <= sel_b1_d;
      sel_b2_q <= sel_b2_d;
      busy_q   <= busy_d;
    end
  end

  assign sel_b1     = sel_b1_q;
  assign sel_b2     = sel_b2_q;
  assign busy       = busy_q;
  assign switch_cnt = swcnt_q;

endmodule

// File: tb/tb_sel_switch_ctrl.sv
// Directed bench for sel_switch_ctrl: main instance (HOLD 4, CNT_W 8) and a
// second instance (HOLD 1, CNT_W 2) for the counter-saturation scenario.
module tb_sel_switch_ctrl;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       req_b, force_a;
  logic       sel_b1, sel_b2, busy;
  logic [7:0] switch_cnt;

  logic       req_b2, force_a2;
  logic       s2_b1, s2_b2, s2_busy;
  logic [1:0] s2_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sel_switch_ctrl #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .req_b      (req_b),
    .force_a    (force_a),
    .sel_b1     (sel_b1),
    .sel_b2     (sel_b2),
    .busy       (busy),
    .switch_cnt (switch_cnt)
  );

  sel_switch_ctrl #(.HOLD_CYCLES(1), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .areset_n   (areset_n),
    .req_b      (req_b2),
    .force_a    (force_a2),
    .sel_b1     (s2_b1),
    .sel_b2     (s2_b2),
    .busy       (s2_busy),
    .switch_cnt (s2_cnt)
  );

  // sel_b2 must never be high without sel_b1, on either instance.
  always @(negedge clk) begin
    if (areset_n === 1'b1) begin
      checks++;
      if ((sel_b2 && !sel_b1) || (s2_b2 && !s2_b1)) begin
        errors++;
        $display("FAIL invariant t=%0t main b1=%b b2=%b sat b1=%b b2=%b (b2 requires b1)",
                 $time, sel_b1, sel_b2, s2_b1, s2_b2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    areset_n = 1'b0; req_b = 1'b0; force_a = 1'b0; req_b2 = 1'b0; force_a2 = 1'b0;
    #2;
    got = {sel_b1, sel_b2, busy, switch_cnt};
    checks++;
    if (got !== 11'd0) begin
      errors++;
      $display("FAIL reset_values got %b exp %b", got, 11'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      got = {sel_b1, sel_b2, busy, switch_cnt};
      checks++;
      if (got !== 11'd0) begin
        errors++;
        $display("FAIL reset_release j=%0d got %b exp %b", j, got, 11'd0);
      end
    end
  endtask

  task automatic test_clean_switch();
    logic [10:0] got, exp;
    req_b = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      tick();
      exp = {(j >= 6) ? 1'b1 : 1'b0, (j >= 7) ? 1'b1 : 1'b0,
             (j >= 2 && j <= 6) ? 1'b1 : 1'b0, (j >= 7) ? 8'd1 : 8'd0};
      got = {sel_b1, sel_b2, busy, switch_cnt};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clean_switch edge k+%0d got b1/b2/busy/cnt=%b exp %b", j, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back_bounce();
    logic [10:0] got, exp;
    req_b = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (j == 1) req_b = 1'b1;
      exp = {1'b1, 1'b1, (j == 2 || j == 3) ? 1'b1 : 1'b0, 8'd1};
      got = {sel_b1, sel_b2, busy, switch_cnt};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bounce edge k+%0d got %b exp %b", j, got, exp);
      end
    end
    req_b = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      tick();
      exp = {(j < 7) ? 1'b1 : 1'b0, (j < 6) ? 1'b1 : 1'b0,
             (j >= 2 && j <= 6) ? 1'b1 : 1'b0, 8'd1};
      got = {sel_b1, sel_b2, busy, switch_cnt};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL switch_to_a edge k+%0d got %b exp %b", j, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [10:0] got, exp;
    req_b = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 2) req_b = 1'b0;
      exp = {1'b0, 1'b0, (j >= 2 && j <= 4) ? 1'b1 : 1'b0, 8'd1};
      got = {sel_b1, sel_b2, busy, switch_cnt};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL glitch edge k+%0d got %b exp %b", j, got, exp);
      end
    end
  endtask

  task automatic test_force();
    logic [10:0] got, exp;
    req_b = 1'b1;
    repeat (8) tick();
    got = {sel_b1, sel_b2, busy, switch_cnt};
    checks++;
    if (got !== {3'b110, 8'd2}) begin
      errors++;
      $display("FAIL force_setup got %b exp %b", got, {3'b110, 8'd2});
    end
    force_a = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      tick();
      if (j == 0) force_a = 1'b0;
      exp = {(j == 0 || j >= 6) ? 1'b1 : 1'b0, (j >= 7) ? 1'b1 : 1'b0,
             (j == 0 || (j >= 2 && j <= 6)) ? 1'b1 : 1'b0, (j >= 7) ? 8'd3 : 8'd2};
      got = {sel_b1, sel_b2, busy, switch_cnt};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL force edge k+%0d got %b exp %b", j, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got;
    tick();
    #2;
    areset_n = 1'b0;
    req_b    = 1'b0;
    #1;
    got = {sel_b1, sel_b2, busy, switch_cnt};
    checks++;
    if (got !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_async got %b exp %b", got, 11'd0);
    end
    @(posedge clk);
    @(negedge clk);
    areset_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      got = {sel_b1, sel_b2, busy, switch_cnt};
      checks++;
      if (got !== 11'd0) begin
        errors++;
        $display("FAIL reset_mid_after j=%0d got %b exp %b", j, got, 11'd0);
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    logic [1:0] exp;
    for (int i = 0; i < 5; i++) begin
      req_b2 = 1'b1;
      n = 0;
      while (s2_b2 !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (n != 5) begin
        errors++;
        $display("FAIL sat_to_b_latency cycle %0d got %0d edges exp 5", i, n);
      end
      exp = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++;
      if (s2_cnt !== exp) begin
        errors++;
        $display("FAIL sat_count cycle %0d got %0d exp %0d", i, s2_cnt, exp);
      end
      req_b2 = 1'b0;
      n = 0;
      while (s2_b1 !== 1'b0 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (n != 5) begin
        errors++;
        $display("FAIL sat_to_a_latency cycle %0d got %0d edges exp 5", i, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_switch();
    test_back_to_back_bounce();
    test_glitch();
    test_force();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
